// File: rtl/aoi21_arc_exerciser.sv
// aoi21_arc_exerciser: sweeps the 15 timing-arc vectors of an aoi21 cell and checks ZN against !((A1&A2)|B).
module aoi21_arc_exerciser #(
  parameter int SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       start,
  input  logic       dut_zn,
  output logic       dut_a1,
  output logic       dut_a2,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [3:0] first_fail,
  output logic [3:0] step
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  state_t r_state, w_next;
  logic [3:0] r_step, r_cnt, r_err, r_ff, w_nstep, w_err_n;
  logic [2:0] r_vec, w_nvec;
  logic r_pass, w_settled, w_miss, w_go, w_last;
  // {A1,A2,B}: the middle step of each arc raises the toggled input
  function automatic logic [2:0] arc_vec(input logic [3:0] s);
    logic t;
    t = s == 4'd1 || s == 4'd4 || s == 4'd7 || s == 4'd10 || s == 4'd13;
    return s < 4'd3 ? {t, 2'b10} : s < 4'd6 ? {1'b1, t, 1'b0} : s < 4'd9 ? {2'b00, t} :
           s < 4'd12 ? {2'b01, t} : {2'b10, t};
  endfunction
  always_comb begin
    w_go = r_state == IDLE && start;
    w_last = r_step == 4'd14;
    w_settled = r_cnt == 4'(SETTLE - 1);
    w_miss = dut_zn != ~((r_vec[2] & r_vec[1]) | r_vec[0]);
    busy = r_state == DRIVE || r_state == SAMPLE;
    done = r_state == DONE;
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? DRIVE : IDLE;
      DRIVE:   w_next = w_settled ? SAMPLE : DRIVE;
      SAMPLE:  w_next = w_last ? DONE : DRIVE;
      default: w_next = IDLE;
    endcase
    w_nstep = w_go ? 4'd0 : (r_state == SAMPLE && !w_last) ? r_step + 4'd1 : r_step;
    w_nvec = (w_next == DRIVE || w_next == SAMPLE) ? arc_vec(w_nstep) : 3'b000;
    w_err_n = (r_state == SAMPLE && w_miss && r_err != 4'hF) ? r_err + 4'd1 : r_err;
  end
  always_ff @(posedge CLK or negedge RN)
    if (!RN) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge CLK or negedge RN)
    if (!RN) begin
      r_step <= 4'd0;
      r_cnt <= 4'd0;
      r_vec <= 3'b000;
      r_err <= 4'd0;
      r_ff <= 4'hF;
      r_pass <= 1'b0;
    end else begin
      r_step <= w_nstep;
      r_vec <= w_nvec;
      r_cnt <= (r_state == DRIVE && !w_settled) ? r_cnt + 4'd1 : 4'd0;
      if (w_go) begin
        r_err <= 4'd0;
        r_ff <= 4'hF;
        r_pass <= 1'b0;
      end else begin
        r_err <= w_err_n;
        if (r_state == SAMPLE && w_miss && r_ff == 4'hF) r_ff <= r_step;
        if (r_state == SAMPLE && w_last) r_pass <= w_err_n == 4'd0;
      end
    end
  assign {dut_a1, dut_a2, dut_b} = r_vec;
  assign step = r_step;
  assign err_cnt = r_err;
  assign first_fail = r_ff;
  assign pass = r_pass;
endmodule

// File: doc/aoi21_arc_exerciser.md
AOI21_ARC_EXERCISER -- requirements
Module: aoi21_arc_exerciser

Interface
REQ-001 SHALL have parameter SETTLE, default 2, legal range 1..15: cycles each vector is held before ZN is sampled.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to run the full arc sweep.
REQ-005 SHALL have port dut_zn  input  1  ZN output of the aoi21 cell under test (ZN = !((A1&A2)|B)).
REQ-006 SHALL have ports dut_a1, dut_a2, dut_b  output  1 each  registered stimulus to the cell inputs A1, A2, B.
REQ-007 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when a sweep completes.
REQ-009 SHALL have port pass  output  1  high when the last completed sweep had zero mismatches.
REQ-010 SHALL have port err_cnt  output  4  mismatch count of the current or last sweep.
REQ-011 SHALL have port first_fail  output  4  step index of the first mismatch; 4'hF if none.
REQ-012 SHALL have port step  output  4  current step index, 0..14.

Function
REQ-013 SHALL run a fixed 15-step table of 5 arcs x 3 phases: base (toggled input 0), rise (1), fall (0).
REQ-014 Arc 0 (steps 0-2) SHALL toggle A1 with A2=1, B=0; arc 1 (steps 3-5) SHALL toggle A2 with A1=1, B=0.
REQ-015 Arcs 2, 3, 4 (steps 6-8, 9-11, 12-14) SHALL toggle B with (A1,A2) = (0,0), (0,1), (1,0) respectively.
REQ-016 Expected ZN per step SHALL be computed as !((A1&A2)|B) from the applied vector, not stored separately.
REQ-017 SHALL use FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-018 IDLE: start=1 -> DRIVE at step 0; err_cnt cleared, first_fail=4'hF, pass=0, busy=1 from next cycle.
REQ-019 DRIVE: step vector on dut_* from the first DRIVE cycle; held SETTLE cycles by a settle counter; then SAMPLE.
REQ-020 SAMPLE (1 cycle): compare dut_zn to expected; on mismatch increment err_cnt and, if first_fail=4'hF, load step.
REQ-021 SAMPLE with step<14 SHALL advance step and return to DRIVE; with step=14 SHALL go to DONE.
REQ-022 Each step SHALL occupy exactly SETTLE+1 cycles; sweep length 15*(SETTLE+1) cycles from first DRIVE cycle.
REQ-023 DONE (1 cycle): done=1, busy=0, pass=(err_cnt==0 including final sample); then IDLE.
REQ-024 err_cnt SHALL saturate at 15, never wrap.
REQ-025 start while busy or in DONE SHALL be ignored; start in the cycle after DONE SHALL begin a new sweep.
REQ-026 In IDLE dut_a1/a2/b SHALL hold 0,0,0 and results SHALL hold the last sweep values.

Reset
REQ-027 RN low SHALL asynchronously force IDLE, step=0, dut_a1/a2/b=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=4'hF.
REQ-028 RN asserted mid-sweep SHALL abort it with no done pulse; sweep only restarts on a new start after RN release.
REQ-029 Release of RN SHALL take effect at the next CLK edge; no start is sampled in the release cycle.

Verification
REQ-030 SETTLE=2, ideal aoi21 model on dut_zn, start pulse -> done 45 cycles after first DRIVE cycle, pass=1, err_cnt=0, first_fail=4'hF.
REQ-031 dut_zn stuck at 1 -> err_cnt=5, first_fail=1, pass=0.
REQ-032 dut_zn stuck at 0 -> err_cnt=10, first_fail=0, pass=0.
REQ-033 dut_zn = !(A1&A2) (B ignored) -> err_cnt=3 (steps 7, 10, 13), first_fail=7, pass=0.
REQ-034 RN pulsed low at step 6 -> all outputs at reset values immediately, no done; next start gives full 45-cycle sweep with pass=1.
REQ-035 start held high for 60 cycles with ideal model -> exactly one sweep per IDLE entry, done pulses 1 cycle wide, stimulus sequence matches REQ-014/015 step by step.
